// File: rtl/lpc_autocorr.sv
// lpc_autocorr: streaming autocorrelation R[0..ORDER] over N-sample frames,
// drained as scaled, saturated words under ddr_wait backpressure, with a 4-register CSR block.
module lpc_autocorr #(
  parameter int ORDER = 10,
  parameter int DW    = 16,
  parameter int ACCW  = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] d_in,
  input  logic                 v,
  output logic signed [DW-1:0] d_out,
  output logic                 vout,
  input  logic                 ddr_wait,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [1:0]           addr,
  input  logic                 read,
  input  logic                 write
);
  localparam int IW = $clog2(ORDER + 1);
  localparam logic signed [ACCW-1:0] MAXV = (ACCW'(1) <<< (DW - 1)) - ACCW'(1);
  localparam logic signed [ACCW-1:0] MINV = -MAXV - ACCW'(1);
  logic [15:0] n_q, n_d, len_q, len_d, cnt_q, cnt_d, fcnt_q, fcnt_d, ocnt_q, ocnt_d, cur_len;
  logic [5:0] sh_q, sh_d;
  logic en_q, en_d, pend_q, pend_d, vout_q, vout_d, acc_en, fend, clr;
  logic [IW-1:0] idx_q, idx_d;
  logic signed [DW-1:0] dout_q, dout_d;
  logic signed [DW-1:0] hist_q [1:ORDER];
  logic signed [DW-1:0] hist_d [1:ORDER];
  logic signed [2*DW-1:0] prod [0:ORDER];
  logic signed [ACCW-1:0] acc_q [0:ORDER];
  logic signed [ACCW-1:0] acc_d [0:ORDER];
  logic signed [ACCW-1:0] s_q [0:ORDER];
  logic signed [ACCW-1:0] s_d [0:ORDER];
  logic signed [ACCW-1:0] sum [0:ORDER];
  logic signed [ACCW-1:0] shv;
  logic [31:0] rd_q, rd_d;
  assign d_out    = dout_q;
  assign vout     = vout_q;
  assign readdata = rd_q;
  always_comb begin
    acc_en  = v && en_q;
    cur_len = (cnt_q == 16'd0) ? ((n_q == 16'd0) ? 16'd1 : n_q) : len_q;
    fend    = acc_en && (cnt_q + 16'd1 == cur_len);
    clr     = write && addr == 2'd3 && writedata[1];
    prod[0] = d_in * d_in;
    sum[0]  = acc_q[0] + ACCW'(prod[0]);
    for (int k = 1; k <= ORDER; k++) begin
      prod[k] = d_in * hist_q[k];
      sum[k]  = acc_q[k] + ACCW'(prod[k]);
    end
    n_d    = (write && addr == 2'd0) ? writedata[15:0] : n_q;
    sh_d   = (write && addr == 2'd1) ? writedata[5:0] : sh_q;
    en_d   = (write && addr == 2'd3) ? writedata[0] : en_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    hist_d = hist_q;
    s_d    = s_q;
    pend_d = pend_q;
    idx_d  = idx_q;
    vout_d = 1'b0;
    dout_d = dout_q;
    if (!en_q || fend) begin
      acc_d  = '{default: '0};
      hist_d = '{default: '0};
      cnt_d  = 16'd0;
    end else if (acc_en) begin
      acc_d     = sum;
      hist_d[1] = d_in;
      for (int k = 2; k <= ORDER; k++) hist_d[k] = hist_q[k-1];
      cnt_d     = cnt_q + 16'd1;
    end
    if (acc_en && cnt_q == 16'd0) len_d = cur_len;
    shv = s_q[idx_q] >>> sh_q;
    if (pend_q && !ddr_wait) begin
      vout_d = 1'b1;
      dout_d = (shv > MAXV) ? MAXV[DW-1:0] : (shv < MINV) ? MINV[DW-1:0] : shv[DW-1:0];
      idx_d  = idx_q + IW'(1);
      pend_d = (idx_q != IW'(ORDER));
    end
    // a new snapshot always wins over an in-flight drain and restarts it
    if (fend) begin
      s_d    = sum;
      pend_d = 1'b1;
      idx_d  = '0;
    end
    fcnt_d = clr ? 16'd0 : (fend && fcnt_q != 16'hFFFF) ? fcnt_q + 16'd1 : fcnt_q;
    ocnt_d = clr ? 16'd0 : (fend && pend_q && ocnt_q != 16'hFFFF) ? ocnt_q + 16'd1 : ocnt_q;
    rd_d   = !read ? rd_q :
             (addr == 2'd0) ? {16'd0, n_q} :
             (addr == 2'd1) ? {26'd0, sh_q} :
             (addr == 2'd2) ? {ocnt_q, fcnt_q} : {29'd0, pend_q, 1'b0, en_q};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q    <= 16'd256;
      sh_q   <= '0;
      en_q   <= 1'b0;
      len_q  <= '0;
      cnt_q  <= '0;
      fcnt_q <= '0;
      ocnt_q <= '0;
      acc_q  <= '{default: '0};
      hist_q <= '{default: '0};
      s_q    <= '{default: '0};
      pend_q <= 1'b0;
      idx_q  <= '0;
      vout_q <= 1'b0;
      dout_q <= '0;
      rd_q   <= '0;
    end else begin
      n_q    <= n_d;
      sh_q   <= sh_d;
      en_q   <= en_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      fcnt_q <= fcnt_d;
      ocnt_q <= ocnt_d;
      acc_q  <= acc_d;
      hist_q <= hist_d;
      s_q    <= s_d;
      pend_q <= pend_d;
      idx_q  <= idx_d;
      vout_q <= vout_d;
      dout_q <= dout_d;
      rd_q   <= rd_d;
    end
  end
endmodule
